oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
- Sprite DMA controller for the CPU data bus.
- A CPU write to the trigger register latches a source page. The block halts the CPU and drives the bus through the databus DMA override. It copies 256 bytes from {page,00}..{page,FF} into the PPU OAM data port, alternating one read cycle and one write cycle per byte.
- Sits beside the CPU core and feeds DMA/DMA_ADDR into the databus mux.

Parameters:
TRIGGER_ADDR, 16'h4014, CPU address whose write starts a transfer
OAM_DATA_ADDR, 16'h2004, destination address written once per byte
XFER_LEN, 256, bytes per transfer (power of two, max 256)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
CPU_CE  in  1  CPU cycle strobe; exactly one CLK per CPU cycle is high
CPU_ADDR  in  16  CPU address bus
CPU_WR  in  1  CPU R/W: 1 = read cycle, 0 = write cycle
CPU_DO  in  8  CPU write data
BUS_DATA  in  8  databus BUS_OUT, valid at the CPU_CE edge ending a read
DMA  out  1  selects DMA_ADDR in the databus
DMA_ADDR  out  16  DMA bus address
DMA_WR  out  1  DMA R/W, same polarity as CPU_WR
DMA_DO  out  8  DMA write data
CPU_RDY  out  1  0 = CPU core frozen this cycle
BUSY  out  1  transfer in progress

Behaviour:
- Clocking: all state advances on rising CLK only when CPU_CE=1. With CPU_CE=0, all registers hold. All outputs are registered.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, PARITY=0, page=0, idx=0, data latch=0.
  - DMA=0, DMA_ADDR=0, DMA_WR=1, DMA_DO=0, CPU_RDY=1, BUSY=0.
  - A partial transfer is abandoned and is not resumed after reset.
- PARITY: toggles on every CPU_CE, including in IDLE. Cycles with PARITY=0 are "get" cycles; cycles with PARITY=1 are "put" cycles.
- Trigger: in IDLE, a CE where CPU_ADDR==TRIGGER_ADDR and CPU_WR=0 latches page=CPU_DO and moves to HALT.
  - A write to TRIGGER_ADDR in any non-IDLE state is ignored; page is unchanged.
  - CPU reads of TRIGGER_ADDR never trigger.
- States and transitions:
  - IDLE: CPU_RDY=1, DMA=0, BUSY=0.
  - HALT: one CPU cycle. CPU_RDY=0, BUSY=1, DMA=0. The next state is ALIGN if the following cycle is a put cycle, otherwise READ.
  - ALIGN: one dummy cycle. CPU_RDY=0, DMA=0. Next state is READ.
  - READ: always a get cycle.
    - DMA=1, DMA_WR=1, DMA_ADDR={page,idx}.
    - At the closing CE, latch BUS_DATA into the data latch. Next state is WRITE.
  - WRITE: always a put cycle.
    - DMA=1, DMA_WR=0, DMA_ADDR=OAM_DATA_ADDR, DMA_DO=data latch.
    - At the closing CE, idx increments mod 256.
    - If idx was XFER_LEN-1, next state is DONE; otherwise READ.
  - DONE: one cycle. DMA=0, CPU_RDY=1, BUSY=0, DMA_WR=1. Next state is IDLE. A trigger write is accepted again from the first IDLE cycle.
- Timing: CPU_RDY is low for 1+2·XFER_LEN cycles (513) when HALT lands on a put cycle, and 514 when ALIGN is inserted.
- Addressing: idx is 8 bits. DMA_ADDR low byte wraps within the page and never carries into page. Page $FF reads $FF00–$FFFF (PRG ROM). Page $00–$1F reads system RAM.
- Invariant: DMA=1 only in READ and WRITE, never in the same cycle as CPU_RDY=1.

Test Plan:
- Even start: reset, align so the trigger write is on a get cycle, write $02 to $4014. Preload RAM $0200+i = i^$5A.
  - 256 writes to $2004 with data i^$5A in order.
  - CPU_RDY low for exactly 513 CEs.
  - DMA high for exactly 512 CEs.
- Odd start: same stimulus shifted one CPU cycle.
  - ALIGN inserted, CPU_RDY low for 514 CEs.
  - First DMA read address is $0200 on a PARITY=0 cycle.
- Retrigger while busy: write $03 to $4014 at byte 40.
  - Transfer continues from $0228 through $02FF.
  - No second transfer; BUSY falls once.
- Reset mid-op: assert RESET_N=0 asynchronously (between CLK edges) during byte 100.
  - All outputs take reset values immediately.
  - After release, no bus activity until a new trigger.
- CE gaps: drive CPU_CE high only 1 of every 3 CLKs with random stretches.
  - Same write sequence and same CE counts as the even-start case.
  - Outputs stable across non-CE clocks.
- Non-trigger traffic: CPU writes to $4015, $4016 and $2004, and a read of $4014.
  - BUSY, DMA and CPU_RDY stay at 0/0/1.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// oam_dma_ctrl_if : CPU-side inputs and databus DMA-override outputs
// Revision : 1.0
// -----------------------------------------------------------------------------
interface oam_dma_ctrl_if;
  logic        CPU_CE;
  logic [15:0] CPU_ADDR;
  logic        CPU_WR;
  logic [7:0]  CPU_DO;
  logic [7:0]  BUS_DATA;
  logic        DMA;
  logic [15:0] DMA_ADDR;
  logic        DMA_WR;
  logic [7:0]  DMA_DO;
  logic        CPU_RDY;
  logic        BUSY;

  modport master (
    input  CPU_CE, CPU_ADDR, CPU_WR, CPU_DO, BUS_DATA,
    output DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_RDY, BUSY
  );

  modport slave (
    output CPU_CE, CPU_ADDR, CPU_WR, CPU_DO, BUS_DATA,
    input  DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_RDY, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// oam_dma_ctrl : sprite DMA, copies one 256-byte page into the OAM data port
// Revision : 1.0
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  wire logic      CLK,
  input  wire logic      RESET_N,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_dma;
  logic [15:0] r_dma_addr;
  logic        r_dma_wr;
  logic [7:0]  r_dma_do;
  logic        r_cpu_rdy;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [7:0]  w_page_nxt;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_trigger;
  logic        w_dma;
  logic [15:0] w_dma_addr;
  logic        w_dma_wr;
  logic        w_cpu_rdy;

  assign w_trigger = (bus.CPU_ADDR == TRIGGER_ADDR) && !bus.CPU_WR;

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_page_nxt  = bus.CPU_DO;
          w_idx_nxt   = 8'h00;
          w_state_nxt = S_HALT;
        end
      end
      // r_parity is this cycle's parity; the next cycle has the opposite one
      S_HALT:  w_state_nxt = r_parity ? S_READ : S_ALIGN;
      S_ALIGN: w_state_nxt = S_READ;
      S_READ: begin
        w_data_nxt  = bus.BUS_DATA;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_idx_nxt   = r_idx + 8'd1;
        w_state_nxt = (r_idx == c_LAST_IDX) ? S_DONE : S_READ;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  assign w_dma      = (w_state_nxt == S_READ) || (w_state_nxt == S_WRITE);
  assign w_dma_wr   = (w_state_nxt != S_WRITE);
  assign w_cpu_rdy  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
  assign w_dma_addr = (w_state_nxt == S_READ)  ? {w_page_nxt, w_idx_nxt} :
                      (w_state_nxt == S_WRITE) ? OAM_DATA_ADDR : 16'h0000;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_parity   <= 1'b0;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_data     <= 8'h00;
      r_dma      <= 1'b0;
      r_dma_addr <= 16'h0000;
      r_dma_wr   <= 1'b1;
      r_dma_do   <= 8'h00;
      r_cpu_rdy  <= 1'b1;
      r_busy     <= 1'b0;
    end else if (bus.CPU_CE) begin
      r_state    <= w_state_nxt;
      r_parity   <= ~r_parity;
      r_page     <= w_page_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_dma      <= w_dma;
      r_dma_addr <= w_dma_addr;
      r_dma_wr   <= w_dma_wr;
      r_dma_do   <= w_data_nxt;
      r_cpu_rdy  <= w_cpu_rdy;
      r_busy     <= !w_cpu_rdy;
    end
  end

  assign bus.DMA      = r_dma;
  assign bus.DMA_ADDR = r_dma_addr;
  assign bus.DMA_WR   = r_dma_wr;
  assign bus.DMA_DO   = r_dma_do;
  assign bus.CPU_RDY  = r_cpu_rdy;
  assign bus.BUSY     = r_busy;

endmodule
`default_nettype wire
